// File: rtl/sbox_share_sched_if.sv
// Requester-side bus of the shared S-box scheduler: request/grant handshake and tagged responses.
interface sbox_share_sched_if #(
    parameter int NUM_REQ = 4
);
    localparam int IW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ-1:0]   req_last;
    logic [8*NUM_REQ-1:0] req_byte;
    logic [NUM_REQ-1:0]   gnt;
    logic [NUM_REQ-1:0]   rsp_valid;
    logic [7:0]           rsp_byte;
    logic                 busy;
    logic [IW-1:0]        owner;

    modport master (
        output req, req_last, req_byte,
        input  gnt, rsp_valid, rsp_byte, busy, owner
    );

    modport slave (
        input  req, req_last, req_byte,
        output gnt, rsp_valid, rsp_byte, busy, owner
    );
endinterface

// File: rtl/sbox_share_sched.sv
// Round-robin, burst-locked scheduler sharing one combinational S-box among NUM_REQ requesters.
// Owns the registered S-box input and the registered, tagged response.
//
// state | meaning
// IDLE  | arbitrate round-robin from rr_ptr; single-byte bursts complete here
// LOCK  | grant locked to owner until req_last, BURST_MAX bytes, or owner drops req
module sbox_share_sched #(
    parameter int NUM_REQ   = 4,
    parameter int BURST_MAX = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    sbox_share_sched_if.slave bus,
    output logic [7:0]        sbox_in,
    input  logic [7:0]        sbox_out
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(BURST_MAX + 1);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t             state, state_nxt;
    logic [IW-1:0]      rr_ptr, rr_ptr_nxt;
    logic [IW-1:0]      owner, owner_nxt;
    logic [CW-1:0]      count, count_nxt;
    logic [IW-1:0]      win, acc_idx, tag1;
    logic               found, accept, acc_last, v1;
    logic [7:0]         acc_byte, rsp_byte;
    logic [NUM_REQ-1:0] gnt, rsp_valid;

    function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] p);
        return (p == IW'(NUM_REQ - 1)) ? '0 : p + IW'(1);
    endfunction

    function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return IW'(s);
    endfunction

    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && bus.req[rr_idx(rr_ptr, k)]) begin
                found = 1'b1;
                win   = rr_idx(rr_ptr, k);
            end
        end
    end

    always_comb begin
        gnt = '0;
        if (state == IDLE) gnt[win] = found;
        else               gnt[owner] = bus.req[owner];
    end

    assign accept   = |gnt;
    assign acc_idx  = (state == IDLE) ? win : owner;
    assign acc_byte = bus.req_byte[{acc_idx, 3'b000} +: 8];
    assign acc_last = bus.req_last[acc_idx];

    always_comb begin
        state_nxt  = state;
        rr_ptr_nxt = rr_ptr;
        owner_nxt  = owner;
        count_nxt  = count;
        case (state)
            IDLE: begin
                if (accept) begin
                    owner_nxt = win;
                    count_nxt = CW'(1);
                    if (acc_last || BURST_MAX == 1) rr_ptr_nxt = next_ptr(win);
                    else                            state_nxt  = LOCK;
                end
            end
            LOCK: begin
                if (accept) begin
                    count_nxt = count + CW'(1);
                    if (acc_last || (count + CW'(1)) == CW'(BURST_MAX)) begin
                        state_nxt  = IDLE;
                        rr_ptr_nxt = next_ptr(owner);
                    end
                end else begin
                    // owner let go: end the burst, nobody is granted this cycle
                    state_nxt  = IDLE;
                    rr_ptr_nxt = next_ptr(owner);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            rr_ptr <= '0;
            owner  <= '0;
            count  <= '0;
        end else begin
            state  <= state_nxt;
            rr_ptr <= rr_ptr_nxt;
            owner  <= owner_nxt;
            count  <= count_nxt;
        end
    end

    // two-stage lookup: register the byte into the S-box, register its result back out
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sbox_in   <= '0;
            v1        <= 1'b0;
            tag1      <= '0;
            rsp_valid <= '0;
            rsp_byte  <= '0;
        end else begin
            v1 <= accept;
            if (accept) begin
                sbox_in <= acc_byte;
                tag1    <= acc_idx;
            end
            rsp_valid <= '0;
            if (v1) begin
                rsp_valid[tag1] <= 1'b1;
                rsp_byte        <= sbox_out;
            end
        end
    end

    assign bus.gnt       = gnt;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_byte  = rsp_byte;
    assign bus.owner     = owner;
    assign bus.busy      = (state == LOCK) | v1 | (|rsp_valid);
endmodule
